// File: rtl/dt_walk_pkg.sv
// Shared types and width/offset helpers for the decision-tree walk engine.
package dt_walk_pkg;

  // Engine states: wait for a vector, walk the node table, present the result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // clog2 that never returns zero, so every field is at least one bit wide.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int fsel_w(input int n_feat);
    return clog2_min1(n_feat);
  endfunction

  function automatic int idx_w(input int n_nodes);
    return clog2_min1(n_nodes);
  endfunction

  function automatic int depth_w(input int max_depth);
    return clog2_min1(max_depth + 1);
  endfunction

  // Node entry packing, MSB to LSB: {leaf, feat_sel, left, right, class}.
  function automatic int entry_w(input int n_feat, input int n_nodes, input int class_w);
    return 1 + fsel_w(n_feat) + 2 * idx_w(n_nodes) + class_w;
  endfunction

  function automatic int off_right(input int class_w);
    return class_w;
  endfunction

  function automatic int off_left(input int class_w, input int n_nodes);
    return class_w + idx_w(n_nodes);
  endfunction

  function automatic int off_fsel(input int class_w, input int n_nodes);
    return class_w + 2 * idx_w(n_nodes);
  endfunction

endpackage

// File: rtl/dt_node_table.sv
// Register-resident node table: one write port, one combinational read port.
// Every entry resets to a class-0 leaf so an unprogrammed engine is harmless.
module dt_node_table
  import dt_walk_pkg::*;
#(
  parameter int N_NODES = 64,
  parameter int IDX_W   = 6,
  parameter int ENTRY_W = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]   raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  // Leaf flag is the MSB; all other fields zero.
  localparam logic [ENTRY_W-1:0] RST_ENTRY = {1'b1, {(ENTRY_W-1){1'b0}}};

  logic [ENTRY_W-1:0] mem_q [N_NODES];

  // Entry storage with table-wide asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NODES; i++) mem_q[i] <= RST_ENTRY;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dt_walk_engine.sv
// Programmable decision-tree classifier: walks the node table one node per clock.
module dt_walk_engine
  import dt_walk_pkg::*;
#(
  parameter int  N_FEAT    = 8,
  parameter int  CLASS_W   = 2,
  parameter int  N_NODES   = 64,
  parameter int  MAX_DEPTH = 8,
  localparam int IDX_W     = idx_w(N_NODES),
  localparam int FSEL_W    = fsel_w(N_FEAT),
  localparam int DEPTH_W   = depth_w(MAX_DEPTH),
  localparam int ENTRY_W   = entry_w(N_FEAT, N_NODES, CLASS_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_FEAT-1:0]  in_feat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLASS_W-1:0] out_class,
  output logic [DEPTH_W-1:0] out_depth,
  output logic               out_err,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [ENTRY_W-1:0] cfg_wdata,
  output logic               cfg_busy
);

  localparam int OFF_RIGHT = off_right(CLASS_W);
  localparam int OFF_LEFT  = off_left(CLASS_W, N_NODES);
  localparam int OFF_FSEL  = off_fsel(CLASS_W, N_NODES);
  localparam int FSEL_N    = 1 << FSEL_W;

  state_e             state_q, state_d;
  logic [N_FEAT-1:0]  feat_q, feat_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [CLASS_W-1:0] class_q, class_d;
  logic [DEPTH_W-1:0] odepth_q, odepth_d;
  logic               err_q, err_d;

  logic [ENTRY_W-1:0] node_rd;
  logic               node_leaf;
  logic [FSEL_W-1:0]  node_fsel;
  logic [IDX_W-1:0]   node_left, node_right;
  logic [CLASS_W-1:0] node_class;
  logic [FSEL_N-1:0]  feat_ext;
  logic               feat_bit;
  logic               idle, accept, tbl_we;

  // Config writes win over an accept, and only land while idle.
  assign idle      = (state_q == ST_IDLE);
  assign in_ready  = idle && !cfg_we;
  assign accept    = in_valid && in_ready;
  assign tbl_we    = idle && cfg_we;
  assign cfg_busy  = !idle;
  assign out_valid = (state_q == ST_DONE);
  assign out_class = class_q;
  assign out_depth = odepth_q;
  assign out_err   = err_q;

  dt_node_table #(
    .N_NODES (N_NODES),
    .IDX_W   (IDX_W),
    .ENTRY_W (ENTRY_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (tbl_we),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_wdata),
    .raddr_i (idx_q),
    .rdata_o (node_rd)
  );

  assign node_leaf  = node_rd[ENTRY_W-1];
  assign node_fsel  = node_rd[OFF_FSEL +: FSEL_W];
  assign node_left  = node_rd[OFF_LEFT +: IDX_W];
  assign node_right = node_rd[OFF_RIGHT +: IDX_W];
  assign node_class = node_rd[CLASS_W-1:0];

  // Selector codes beyond the feature vector fall back to feature bit 0.
  for (genvar gi = 0; gi < FSEL_N; gi++) begin : g_feat_ext
    if (gi < N_FEAT) begin : g_in
      assign feat_ext[gi] = feat_q[gi];
    end else begin : g_out
      assign feat_ext[gi] = feat_q[0];
    end
  end
  assign feat_bit = feat_ext[node_fsel];

  // State, feature latch, walk cursor and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      feat_q   <= '0;
      idx_q    <= '0;
      depth_q  <= '0;
      class_q  <= '0;
      odepth_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      feat_q   <= feat_d;
      idx_q    <= idx_d;
      depth_q  <= depth_d;
      class_q  <= class_d;
      odepth_q <= odepth_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: accept, step one node per cycle, hold the result until taken.
  always_comb begin
    state_d  = state_q;
    feat_d   = feat_q;
    idx_d    = idx_q;
    depth_d  = depth_q;
    class_d  = class_q;
    odepth_d = odepth_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          feat_d  = in_feat;
          idx_d   = '0;
          depth_d = '0;
          state_d = ST_WALK;
        end
      end
      ST_WALK: begin
        if (node_leaf) begin
          class_d  = node_class;
          odepth_d = depth_q;
          err_d    = 1'b0;
          state_d  = ST_DONE;
        end else if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
          class_d  = '0;
          odepth_d = depth_q;
          err_d    = 1'b1;
          state_d  = ST_DONE;
        end else begin
          idx_d   = feat_bit ? node_right : node_left;
          depth_d = depth_q + DEPTH_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dt_walk_engine.sv
// Randomized self-checking bench for dt_walk_engine against a table-walk model.
module tb_dt_walk_engine;

  localparam int N_FEAT    = 8;
  localparam int CLASS_W   = 2;
  localparam int N_NODES   = 64;
  localparam int MAX_DEPTH = 8;
  localparam int IDX_W     = 6;
  localparam int FSEL_W    = 3;
  localparam int DEPTH_W   = 4;
  localparam int ENTRY_W   = 1 + FSEL_W + 2 * IDX_W + CLASS_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [N_FEAT-1:0]  in_feat;
  logic               out_valid;
  logic               out_ready;
  logic [CLASS_W-1:0] out_class;
  logic [DEPTH_W-1:0] out_depth;
  logic               out_err;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_addr;
  logic [ENTRY_W-1:0] cfg_wdata;
  logic               cfg_busy;

  always #5 clk = ~clk;

  dt_walk_engine #(
    .N_FEAT    (N_FEAT),
    .CLASS_W   (CLASS_W),
    .N_NODES   (N_NODES),
    .MAX_DEPTH (MAX_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_depth (out_depth),
    .out_err   (out_err),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_busy  (cfg_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference node table kept as plain field arrays.
  bit m_leaf  [N_NODES];
  int m_fsel  [N_NODES];
  int m_left  [N_NODES];
  int m_right [N_NODES];
  int m_class [N_NODES];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N_NODES; i++) begin
      m_leaf[i] = 1'b1; m_fsel[i] = 0; m_left[i] = 0; m_right[i] = 0; m_class[i] = 0;
    end
  endfunction

  function automatic logic [ENTRY_W-1:0] pack_node(input bit leaf, input int fsel,
                                                   input int l, input int r, input int c);
    return {leaf, FSEL_W'(fsel), IDX_W'(l), IDX_W'(r), CLASS_W'(c)};
  endfunction

  // Follow the tree by the classification rules: returns class, depth and abort flag.
  function automatic void model_walk(input logic [N_FEAT-1:0] f, output int cls,
                                     output int dep, output int err);
    int  idx;
    bit  b;
    idx = 0; dep = 0; err = 0; cls = 0;
    for (int k = 0; k <= MAX_DEPTH + 1; k++) begin
      if (m_leaf[idx]) begin
        cls = m_class[idx];
        return;
      end
      if (dep == MAX_DEPTH) begin
        err = 1; cls = 0;
        return;
      end
      b   = (m_fsel[idx] < N_FEAT) ? f[m_fsel[idx]] : f[0];
      idx = b ? m_right[idx] : m_left[idx];
      dep++;
    end
  endfunction

  task automatic cfg_write(input int addr, input bit leaf, input int fsel, input int l,
                           input int r, input int c);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = IDX_W'(addr);
    cfg_wdata = pack_node(leaf, fsel, l, r, c);
    @(posedge clk);
    #1 cfg_we = 1'b0;
    m_leaf[addr] = leaf; m_fsel[addr] = fsel; m_left[addr] = l;
    m_right[addr] = r; m_class[addr] = c;
  endtask

  // One classification: accept, count latency, optionally stall, then handshake.
  // inject issues an untracked node0 write while the engine is busy.
  task automatic classify(input logic [N_FEAT-1:0] f, input int hold, input bit inject);
    int e_cls, e_dep, e_err, lat;
    bit seen;
    model_walk(f, e_cls, e_dep, e_err);
    @(negedge clk);
    check_val("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_feat  = f;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check_val("busy_after_accept", cfg_busy, 1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (inject && lat == 2) begin
        check_val("busy_at_inject", cfg_busy, 1);
        cfg_we    = 1'b1;
        cfg_addr  = '0;
        cfg_wdata = pack_node(1'b1, 0, 0, 0, 2);
      end
      @(posedge clk);
      #1 lat++;
      cfg_we = 1'b0;
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      check_val("latency_timeout", out_valid, 1);
      return;
    end
    check_val("latency", lat, e_dep + 1);
    check_val("out_class", out_class, e_cls);
    check_val("out_depth", out_depth, e_dep);
    check_val("out_err", out_err, e_err);
    check_val("in_ready_done", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check_val("hold_valid", out_valid, 1);
      check_val("hold_class", out_class, e_cls);
      check_val("hold_depth", out_depth, e_dep);
      check_val("hold_err", out_err, e_err);
      check_val("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_val("valid_after_hs", out_valid, 0);
    check_val("in_ready_after_hs", in_ready, 1);
    $display("txn feat=%02h class=%0d depth=%0d err=%0d lat=%0d hold=%0d",
             f, e_cls, e_dep, e_err, lat, hold);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_feat   = '0;
    out_ready = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_class", out_class, 0);
    check_val("rst_out_depth", out_depth, 0);
    check_val("rst_out_err", out_err, 0);
    check_val("rst_cfg_busy", cfg_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unprogrammed table: everything is a class-0 leaf at depth 0.
    classify(8'hA5, 0, 1'b0);

    // Small tree splitting on feature 2.
    cfg_write(0, 1'b0, 2, 1, 2, 0);
    cfg_write(1, 1'b1, 0, 0, 0, 1);
    cfg_write(2, 1'b1, 0, 0, 0, 3);
    classify(8'h04, 0, 1'b0);
    classify(8'h00, 0, 1'b0);
    classify(8'h04, 5, 1'b0);

    // Write and accept in the same idle cycle: the write wins, no accept.
    @(negedge clk);
    in_valid  = 1'b1;
    in_feat   = 8'h04;
    cfg_we    = 1'b1;
    cfg_addr  = IDX_W'(2);
    cfg_wdata = pack_node(1'b1, 0, 0, 0, 2);
    #1 check_val("coincide_in_ready", in_ready, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    cfg_we = 1'b0;
    check_val("coincide_busy", cfg_busy, 0);
    m_class[2] = 2;
    classify(8'h04, 0, 1'b0);

    // Self-loop at the root: depth abort.
    cfg_write(0, 1'b0, 0, 0, 0, 0);
    classify(8'hFF, 0, 1'b0);

    // A write issued mid-walk is dropped; the same write in idle lands.
    classify(8'h3C, 0, 1'b1);
    classify(8'h00, 0, 1'b0);
    cfg_write(0, 1'b1, 0, 0, 0, 2);
    classify(8'h00, 0, 1'b0);

    // Random tables, including cycles that may abort.
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < N_NODES; a++) begin
        cfg_write(a, ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
                  $urandom_range(0, N_NODES - 1), $urandom_range(0, N_NODES - 1),
                  $urandom_range(0, 3));
      end
      for (int t = 0; t < 12; t++) begin
        classify(N_FEAT'($urandom), $urandom_range(0, 2), 1'b0);
      end
    end

    // Depth-3 chain, then reset in the middle of a walk.
    cfg_write(0, 1'b0, 0, 1, 1, 0);
    cfg_write(1, 1'b0, 0, 2, 2, 0);
    cfg_write(2, 1'b0, 0, 3, 3, 0);
    cfg_write(3, 1'b1, 0, 0, 0, 3);
    classify(8'h00, 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_feat  = 8'h00;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 check_val("pre_rst_busy", cfg_busy, 1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_in_ready", in_ready, 1);
    check_val("midrst_cfg_busy", cfg_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    classify(8'h00, 0, 1'b0);
    for (int t = 0; t < 4; t++) begin
      classify(N_FEAT'($urandom), 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dt_walk_engine.md
# dt_walk_engine

Parametrised, programmable decision-tree classifier. It replaces the fixed, per-model combinational trees with a single engine that walks a register-resident node table one node per clock. The table is loaded through a configuration port, so one netlist serves any trained tree within the size limits. The engine sits between the feature-vector source and the class consumer, with valid/ready handshakes on both sides.

## Interface
- N_FEAT, default 8: feature-vector width in bits; features are binary.
- CLASS_W, default 2: class-label width.
- N_NODES, default 64: node-table entries; must be a power of two. IDX_W = clog2(N_NODES).
- MAX_DEPTH, default 8: maximum number of internal nodes traversed before an abort.
- clk, input, 1: the single clock.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: feature vector valid.
- in_ready, output, 1: engine can accept a vector.
- in_feat, input, N_FEAT: feature vector.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- out_class, output, CLASS_W: class label.
- out_depth, output, clog2(MAX_DEPTH+1): number of internal nodes traversed.
- out_err, output, 1: depth limit was exceeded; out_class is forced to 0.
- cfg_we, input, 1: node-table write strobe.
- cfg_addr, input, IDX_W: entry to write.
- cfg_wdata, input, 1+clog2(N_FEAT)+2*IDX_W+CLASS_W: packed fields {leaf, feat_sel, left, right, class}.
- cfg_busy, output, 1: high when the engine is not IDLE; cfg writes are dropped while it is high.

## Operation
- FSM states: IDLE, WALK, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch in_feat, set idx = 0 and depth = 0, then go to WALK.
- WALK: read node[idx] combinationally.
  - leaf = 1: latch class into out_class, latch depth into out_depth, clear out_err, go to DONE.
  - leaf = 0 and depth == MAX_DEPTH: out_class = 0, out_err = 1, go to DONE.
  - Otherwise: idx becomes right if feat[feat_sel] is 1, left if it is 0. depth increments by 1.
- DONE:
  - out_valid = 1.
  - On out_ready, go to IDLE.
  - out_class, out_depth and out_err hold stable until the handshake completes.
- feat_sel >= N_FEAT reads feature bit 0. This is not an error.
- Config writes:
  - A write completes when cfg_we is high in IDLE, with no accept in the same cycle.
  - If cfg_we and an in_valid accept coincide in IDLE, the write takes priority: in_ready is low in that cycle.
  - In WALK or DONE, writes are dropped silently.
- Reset state of the node table: every entry is {leaf=1, class=0, all other fields 0}. An unprogrammed engine therefore classifies everything as class 0 with depth 0.

## Timing
- Reset values: state IDLE; in_ready 1; out_valid 0; out_class 0; out_depth 0; out_err 0; cfg_busy 0; all latched features 0.
- Accept edge T0 enters WALK. A leaf at depth d transitions to DONE at edge T(d+1), so out_valid is high from T(d+1) onward. Latency is d+1 cycles; the minimum is 1.
- A depth abort produces out_valid at T(MAX_DEPTH+1).
- in_ready is 0 from T0 until the cycle after the out handshake. There is no back-to-back accept in the cycle of the out handshake. Throughput is one vector per (d+3) cycles.
- A config write at edge Tw is visible to a classification accepted at any later edge.
- An rst_n assertion mid-walk or mid-DONE immediately clears all state and the node table to reset values. The in-flight result is lost and out_valid drops asynchronously.

## Structure
- Package dt_walk_pkg holds:
  - the node struct/field offsets {leaf, feat_sel, left, right, class};
  - the state enum;
  - the width helper functions.
- Sub-module dt_node_table: N_NODES x entry-width register file with async reset, one write port and one combinational read port.
- The top level contains only the FSM, the feature latch and the depth counter.

## Test plan
- Reset, then send in_feat=8'hA5 -> out_valid 1 cycle after accept; out_class 0, out_depth 0, out_err 0.
- Program node0 {leaf=0, feat_sel=2, left=1, right=2}, node1 {leaf, class=1}, node2 {leaf, class=3}. Send 8'h04 -> class 3, depth 1, latency 2. Send 8'h00 -> class 1.
- Program the same tree with out_ready held low for 5 cycles after out_valid -> outputs stable and in_ready 0 throughout; in_ready returns 1 the cycle after the handshake.
- Program node0 {leaf=0, left=0, right=0} (a self-loop) -> out_err 1, out_class 0, out_depth MAX_DEPTH=8, latency 9.
- Write node0 to a leaf with class 2 during WALK -> the write is dropped. The next classification still follows the old table. The same write issued in IDLE takes effect.
- Assert rst_n low during WALK of a depth-3 tree -> out_valid 0 and in_ready 1 immediately. The table returns to all class-0 leaves.
